booth_div: RTL

//   Sequential signed divider: the inverse partner of the 16x16 Booth multiplier.

---
 rtl/booth_div_if.sv | 22 ++
 rtl/booth_div.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/booth_div_if.sv
// Start/busy handshake bundle for the sequential signed divider.
interface booth_div_if;
  logic [31:0] x;
  logic [15:0] y;
  logic        start;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;

  modport master (
    output x, y, start,
    input  q, r, busy, done, dz, ovf
  );

  modport slave (
    input  x, y, start,
    output q, r, busy, done, dz, ovf
  );
endinterface

// File: rtl/booth_div.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor, restoring division on
// magnitudes, one quotient bit per clock. Quotient truncates toward zero, remainder
// takes the dividend's sign.
module booth_div (
  input  logic       clk,
  input  logic       rst_n,
  booth_div_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_x, w_x_d;
  logic [15:0] r_y, w_y_d;
  logic        r_sign_q, w_sign_q_d;
  logic        r_sign_r, w_sign_r_d;
  logic [16:0] r_rem, w_rem_d;
  logic [15:0] r_quo, w_quo_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [15:0] r_q, w_q_d;
  logic [15:0] r_r, w_r_d;
  logic        r_busy, w_busy_d;
  logic        r_done, w_done_d;
  logic        r_dz, w_dz_d;
  logic        r_ovf, w_ovf_d;

  logic [32:0] w_ax;
  logic [16:0] w_ay;
  logic [17:0] w_shift;
  logic [17:0] w_diff;
  logic        w_ge;
  logic [15:0] w_q_sat;

  // Magnitudes of the latched operands; |-2^31| and |-32768| fit as unsigned values.
  assign w_ax = {1'b0, r_x[31] ? (~r_x + 32'd1) : r_x};
  assign w_ay = {1'b0, r_y[15] ? (~r_y + 16'd1) : r_y};

  // Borrow of the trial subtraction doubles as the rem >= ay compare.
  assign w_shift = {r_rem, r_quo[15]};
  assign w_diff  = w_shift - {1'b0, w_ay};
  assign w_ge    = ~w_diff[17];

  assign w_q_sat = r_sign_q ? 16'h8000 : 16'h7FFF;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_x      <= '0;
      r_y      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_sign_q <= w_sign_q_d;
      r_sign_r <= w_sign_r_d;
      r_rem    <= w_rem_d;
      r_quo    <= w_quo_d;
      r_cnt    <= w_cnt_d;
      r_q      <= w_q_d;
      r_r      <= w_r_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_dz     <= w_dz_d;
      r_ovf    <= w_ovf_d;
    end
  end

  // Next-state and datapath updates; everything holds unless the current state moves it.
  always_comb begin
    w_state_d  = r_state;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_sign_q_d = r_sign_q;
    w_sign_r_d = r_sign_r;
    w_rem_d    = r_rem;
    w_quo_d    = r_quo;
    w_cnt_d    = r_cnt;
    w_q_d      = r_q;
    w_r_d      = r_r;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    w_dz_d     = r_dz;
    w_ovf_d    = r_ovf;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_x_d      = io_bus.x;
          w_y_d      = io_bus.y;
          w_sign_q_d = io_bus.x[31] ^ io_bus.y[15];
          w_sign_r_d = io_bus.x[31];
          w_dz_d     = 1'b0;
          w_ovf_d    = 1'b0;
          w_busy_d   = 1'b1;
          w_state_d  = StPrep;
        end
      end
      StPrep: begin
        if (w_ay == 17'd0) begin
          w_dz_d    = 1'b1;
          w_state_d = StFix;
        end else if (w_ax[32:16] >= w_ay) begin
          // Upper half already >= divisor: magnitude quotient cannot fit in 16 bits.
          w_ovf_d   = 1'b1;
          w_state_d = StFix;
        end else begin
          w_rem_d   = w_ax[32:16];
          w_quo_d   = w_ax[15:0];
          w_cnt_d   = 4'd0;
          w_state_d = StIter;
        end
      end
      StIter: begin
        w_rem_d = w_ge ? w_diff[16:0] : w_shift[16:0];
        w_quo_d = {r_quo[14:0], w_ge};
        w_cnt_d = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_state_d = StFix;
        end
      end
      StFix: begin
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
        if (r_dz) begin
          w_q_d = 16'hFFFF;
          w_r_d = r_x[15:0];
        end else if (r_ovf) begin
          w_q_d = w_q_sat;
          w_r_d = 16'h0000;
        end else if ((!r_sign_q && r_quo > 16'd32767) || (r_sign_q && r_quo > 16'd32768)) begin
          // Magnitude fits 16 bits unsigned but not the signed result range.
          w_ovf_d = 1'b1;
          w_q_d   = w_q_sat;
          w_r_d   = 16'h0000;
        end else begin
          w_q_d = r_sign_q ? (16'd0 - r_quo) : r_quo;
          w_r_d = r_sign_r ? (16'd0 - r_rem[15:0]) : r_rem[15:0];
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign io_bus.q    = r_q;
  assign io_bus.r    = r_r;
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.dz   = r_dz;
  assign io_bus.ovf  = r_ovf;

endmodule
